// File: rtl/in_pass_pkg.sv
// Shared definitions for the input-pass BEL.
// Provides channel mode encodings and the ConfigBits width helper.
package in_pass_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_REG  = 2'b01;
  localparam logic [1:0] MODE_SYNC = 2'b10;
  localparam logic [1:0] MODE_FILT = 2'b11;

  // Two mode bits per channel followed by the shared filter threshold.
  function automatic int unsigned cfg_width(input int unsigned num_ch,
                                            input int unsigned filt_w);
    return 2 * num_ch + filt_w;
  endfunction

endpackage

// File: rtl/in_pass_channel.sv
// One input-pass channel: pass-through, registered, two-flop synchronised,
// or synchronised plus glitch filter, with a rising-edge pulse output.
// Ports:
//   UserCLK  user clock
//   RESET    synchronous active-high reset
//   I        external pin input
//   MODE     channel mode (see in_pass_pkg)
//   THR      shared filter threshold (0 treated as 1)
//   O        selected output to the switch matrix
//   RISE     one-cycle pulse when the registered output first reads 1
module in_pass_channel
  import in_pass_pkg::*;
#(
  parameter int unsigned FILT_W = 4
) (
  input  logic              UserCLK,
  input  logic              RESET,
  input  logic              I,
  input  logic [1:0]        MODE,
  input  logic [FILT_W-1:0] THR,
  output logic              O,
  output logic              RISE
);

  // One extra bit so the counter increment can never wrap in the compare.
  localparam int unsigned CMP_W = FILT_W + 1;

  logic              q_q,   q_d;
  logic              s1_q,  s1_d;
  logic              s2_q,  s2_d;
  logic              f_q,   f_d;
  logic              p_q,   p_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;

  logic [CMP_W-1:0]  thr_eff;
  logic [CMP_W-1:0]  cnt_inc;
  logic              sel_reg;

  // Next-state for capture, synchroniser and filter; output selection.
  always_comb begin
    q_d     = I;
    s1_d    = I;
    s2_d    = s1_q;
    f_d     = f_q;
    cnt_d   = '0;
    thr_eff = (THR == '0) ? CMP_W'(1) : CMP_W'(THR);
    cnt_inc = CMP_W'(cnt_q) + CMP_W'(1);

    // Filter only moves f after s2 has disagreed for thr_eff consecutive edges.
    if (s2_q != f_q) begin
      if (cnt_inc >= thr_eff) begin
        f_d = s2_q;
      end else begin
        cnt_d = cnt_inc[FILT_W-1:0];
      end
    end

    case (MODE)
      MODE_REG:  sel_reg = q_q;
      MODE_SYNC: sel_reg = s2_q;
      MODE_FILT: sel_reg = f_q;
      default:   sel_reg = 1'b0;
    endcase

    O    = (MODE == MODE_PASS) ? I : sel_reg;
    p_d  = O;
    // Built only from flops, so the pulse cannot glitch.
    RISE = (MODE != MODE_PASS) & sel_reg & ~p_q;
  end

  // Channel state; reset takes priority over all updates.
  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      q_q   <= 1'b0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      f_q   <= 1'b0;
      p_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      f_q   <= f_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/in_pass_sync_filter.sv
// Input-pass BEL for fabric IO tiles: NUM_CH independently configured
// pass channels from external pins into the switch matrix.
// Ports:
//   UserCLK     user clock (only clock)
//   RESET       synchronous active-high reset
//   I           external pin inputs
//   O           outputs to switch matrix
//   RISE        per-channel rising-edge pulse
//   ConfigBits  {THR, mode[NUM_CH-1], ..., mode[0]} static configuration
module in_pass_sync_filter
  import in_pass_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned FILT_W = 4
) (
  input  logic                                  UserCLK,
  input  logic                                  RESET,
  input  logic [NUM_CH-1:0]                     I,
  output logic [NUM_CH-1:0]                     O,
  output logic [NUM_CH-1:0]                     RISE,
  input  logic [cfg_width(NUM_CH, FILT_W)-1:0]  ConfigBits
);

  logic [FILT_W-1:0] thr;

  assign thr = ConfigBits[2*NUM_CH +: FILT_W];

  // One channel per pin; the top only slices configuration.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    in_pass_channel #(
      .FILT_W (FILT_W)
    ) u_ch (
      .UserCLK (UserCLK),
      .RESET   (RESET),
      .I       (I[i]),
      .MODE    (ConfigBits[2*i +: 2]),
      .THR     (thr),
      .O       (O[i]),
      .RISE    (RISE[i])
    );
  end

endmodule

// File: tb/tb_in_pass_sync_filter.sv
// Directed and randomised checks for in_pass_sync_filter (8 channels).
module tb_in_pass_sync_filter;

  localparam int unsigned NCH = 8;
  localparam int unsigned FW  = 4;
  localparam int unsigned CW  = 2 * NCH + FW;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] pin;
  logic [NCH-1:0] o_pins;
  logic [NCH-1:0] rise;
  logic [CW-1:0]  cfg;

  int checks = 0;
  int passes = 0;

  // Scoreboard state for the randomised test.
  logic [15:0] m_modes;
  logic [3:0]  m_thr;
  bit          m_q  [NCH];
  bit          m_s1 [NCH];
  bit          m_s2 [NCH];
  bit          m_f  [NCH];
  bit          m_p  [NCH];
  int          m_cnt[NCH];

  always #5 clk = ~clk;

  in_pass_sync_filter #(
    .NUM_CH (NCH),
    .FILT_W (FW)
  ) dut (
    .UserCLK    (clk),
    .RESET      (rst),
    .I          (pin),
    .O          (o_pins),
    .RISE       (rise),
    .ConfigBits (cfg)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NCH-1:0] pv);
    rst = 1'b1;
    pin = pv;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] eo [3];
    logic [7:0] er [3];
    cfg = {4'd3, 16'h1E79};
    pin = 8'hFF;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o_pins !== 8'h80) $display("FAIL reset_o: got %h want 80", o_pins);
    else passes++;
    checks++;
    if (rise !== 8'h00) $display("FAIL reset_rise: got %h want 00", rise);
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if (o_pins !== 8'hC9) $display("FAIL release_o: got %h want c9", o_pins);
    else passes++;
    checks++;
    if (rise !== 8'h49) $display("FAIL release_rise: got %h want 49", rise);
    else passes++;
    eo = '{8'hDB, 8'hDB, 8'hDB};
    er = '{8'h12, 8'h00, 8'h00};
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (o_pins !== eo[t]) $display("FAIL release_seq_o[%0d]: got %h want %h", t, o_pins, eo[t]);
      else passes++;
      checks++;
      if (rise !== er[t]) $display("FAIL release_seq_rise[%0d]: got %h want %h", t, rise, er[t]);
      else passes++;
    end
    tick();
    checks++;
    if (o_pins !== 8'hFF || rise !== 8'h24)
      $display("FAIL release_filt: got o=%h rise=%h want o=ff rise=24", o_pins, rise);
    else passes++;
  endtask

  task automatic test_modes;
    logic [7:0] eo [6];
    logic [7:0] er [6];
    cfg = {4'd3, 16'h00E4};
    do_reset(8'h00);
    tick();
    tick();
    pin = 8'h0F;
    #1;
    checks++;
    if (o_pins !== 8'h01 || rise !== 8'h00)
      $display("FAIL modes_pre: got o=%h rise=%h want o=01 rise=00", o_pins, rise);
    else passes++;
    eo = '{8'h03, 8'h07, 8'h07, 8'h07, 8'h0F, 8'h0F};
    er = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h08, 8'h00};
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (o_pins !== eo[t] || rise !== er[t])
        $display("FAIL modes_k+%0d: got o=%h rise=%h want o=%h rise=%h", t, o_pins, rise, eo[t], er[t]);
      else passes++;
    end
    pin = 8'h00;
  endtask

  task automatic test_glitch;
    int ec [5];
    cfg = {4'd3, 16'h00C0};
    do_reset(8'h00);
    tick();
    pin = 8'h08;
    tick();
    tick();
    pin = 8'h00;
    ec = '{1, 2, 0, 0, 0};
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (o_pins !== 8'h00 || dut.g_ch[3].u_ch.cnt_q !== 4'(ec[t]))
        $display("FAIL glitch2_k+%0d: got o=%h cnt=%0d want o=00 cnt=%0d",
                 t + 2, o_pins, dut.g_ch[3].u_ch.cnt_q, ec[t]);
      else passes++;
    end
    pin = 8'h08;
    tick();
    tick();
    tick();
    pin = 8'h00;
    tick();
    checks++;
    if (o_pins !== 8'h00) $display("FAIL glitch3_k+3: got %h want 00", o_pins);
    else passes++;
    tick();
    checks++;
    if (o_pins !== 8'h08 || rise !== 8'h08)
      $display("FAIL glitch3_k+4: got o=%h rise=%h want o=08 rise=08", o_pins, rise);
    else passes++;
    tick();
    checks++;
    if (o_pins !== 8'h08 || rise !== 8'h00)
      $display("FAIL glitch3_k+5: got o=%h rise=%h want o=08 rise=00", o_pins, rise);
    else passes++;
  endtask

  task automatic test_thr_bounds;
    for (int th = 0; th < 2; th++) begin
      cfg = {4'(th), 16'h00C0};
      do_reset(8'h00);
      tick();
      pin = 8'h08;
      tick();
      tick();
      checks++;
      if (o_pins !== 8'h00) $display("FAIL thr%0d_k+1: got %h want 00", th, o_pins);
      else passes++;
      tick();
      checks++;
      if (o_pins !== 8'h08) $display("FAIL thr%0d_k+2: got %h want 08", th, o_pins);
      else passes++;
    end
    cfg = {4'hF, 16'h00C0};
    do_reset(8'h00);
    tick();
    pin = 8'h08;
    for (int n = 0; n <= 16; n++) begin
      tick();
      checks++;
      if (o_pins !== ((n >= 16) ? 8'h08 : 8'h00))
        $display("FAIL thrF_k+%0d: got %h want %h", n, o_pins, (n >= 16) ? 8'h08 : 8'h00);
      else passes++;
      if (n == 15) begin
        checks++;
        if (dut.g_ch[3].u_ch.cnt_q !== 4'd14)
          $display("FAIL thrF_cnt_max: got %0d want 14", dut.g_ch[3].u_ch.cnt_q);
        else passes++;
      end
    end
    pin = 8'h00;
  endtask

  task automatic test_mid_reset;
    cfg = {4'd5, 16'h00C0};
    do_reset(8'h00);
    tick();
    pin = 8'h08;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if (dut.g_ch[3].u_ch.cnt_q !== 4'd3)
      $display("FAIL midrst_cnt_before: got %0d want 3", dut.g_ch[3].u_ch.cnt_q);
    else passes++;
    rst = 1'b1;
    tick();
    checks++;
    if (dut.g_ch[3].u_ch.cnt_q !== 4'd0 || dut.g_ch[3].u_ch.f_q !== 1'b0 || o_pins !== 8'h00)
      $display("FAIL midrst_clear: got cnt=%0d f=%b o=%h want cnt=0 f=0 o=00",
               dut.g_ch[3].u_ch.cnt_q, dut.g_ch[3].u_ch.f_q, o_pins);
    else passes++;
    rst = 1'b0;
    for (int t = 6; t <= 11; t++) begin
      tick();
      checks++;
      if (o_pins !== 8'h00) $display("FAIL midrst_k+%0d: got %h want 00", t, o_pins);
      else passes++;
    end
    checks++;
    if (dut.g_ch[3].u_ch.cnt_q !== 4'd4)
      $display("FAIL midrst_cnt_restart: got %0d want 4", dut.g_ch[3].u_ch.cnt_q);
    else passes++;
    tick();
    checks++;
    if (o_pins !== 8'h08 || rise !== 8'h08)
      $display("FAIL midrst_k+12: got o=%h rise=%h want o=08 rise=08", o_pins, rise);
    else passes++;
    pin = 8'h00;
  endtask

  // Advance the scoreboard by one clock edge using the pre-edge inputs.
  task automatic model_edge(input logic [NCH-1:0] pv, input logic r);
    int thre;
    thre = (m_thr == 4'd0) ? 1 : int'(m_thr);
    for (int c = 0; c < int'(NCH); c++) begin
      logic [1:0] md;
      bit         old_o;
      md = m_modes[2*c +: 2];
      case (md)
        2'b00:   old_o = pv[c];
        2'b01:   old_o = m_q[c];
        2'b10:   old_o = m_s2[c];
        default: old_o = m_f[c];
      endcase
      if (r) begin
        m_q[c] = 0; m_s1[c] = 0; m_s2[c] = 0; m_f[c] = 0; m_p[c] = 0; m_cnt[c] = 0;
      end else begin
        if (m_s2[c] == m_f[c]) begin
          m_cnt[c] = 0;
        end else if (m_cnt[c] + 1 >= thre) begin
          m_f[c]   = m_s2[c];
          m_cnt[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
        m_p[c]  = old_o;
        m_s2[c] = m_s1[c];
        m_s1[c] = pv[c];
        m_q[c]  = pv[c];
      end
    end
  endtask

  task automatic test_independence;
    logic [NCH-1:0] eo;
    logic [NCH-1:0] er;
    m_modes = 16'($urandom);
    m_thr   = 4'($urandom_range(0, 4));
    cfg     = {m_thr, m_modes};
    for (int cyc = 0; cyc < 200; cyc++) begin
      pin = 8'($urandom);
      rst = (cyc < 2) || (cyc == 100);
      tick();
      model_edge(pin, rst);
      for (int c = 0; c < int'(NCH); c++) begin
        logic [1:0] md;
        bit         ro;
        md = m_modes[2*c +: 2];
        case (md)
          2'b00:   ro = 0;
          2'b01:   ro = m_q[c];
          2'b10:   ro = m_s2[c];
          default: ro = m_f[c];
        endcase
        eo[c] = (md == 2'b00) ? pin[c] : ro;
        er[c] = (md != 2'b00) && ro && !m_p[c];
      end
      checks++;
      if (o_pins !== eo) $display("FAIL indep_o cyc %0d: got %h want %h", cyc, o_pins, eo);
      else passes++;
      checks++;
      if (rise !== er) $display("FAIL indep_rise cyc %0d: got %h want %h", cyc, rise, er);
      else passes++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pin = '0;
    cfg = '0;
    tick();
    tick();
    test_reset();
    test_modes();
    test_glitch();
    test_thr_bounds();
    test_mid_reset();
    test_independence();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
